seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_bank_reg.sv | 53 +++++
 rtl/seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seg_scan_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Holds the scan phase enum, the default digit count and the dark-anode pattern.
package seg_pkg;

  typedef enum logic {
    PH_DEAD,
    PH_ON
  } phase_t;

  localparam int DIGITS_DEF = 4;
  localparam int DIGITS_MAX = 8;

  // Anodes are active-low, so all ones is a dark display.
  localparam logic [DIGITS_MAX-1:0] AN_OFF = '1;

endpackage

// File: rtl/seg_bank_reg.sv
// Pending/active double buffer for the display contents with a valid/ready update port.
// Ports: clk, rst_n, flush, frame_end, upd_valid/upd_ready, hex/point/blank in, act_* out.
module seg_bank_reg
  import seg_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                frame_end,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   point_in,
  input  logic [DIGITS-1:0]   blank_in,
  output logic [4*DIGITS-1:0] act_hex,
  output logic [DIGITS-1:0]   act_point,
  output logic [DIGITS-1:0]   act_blank
);

  logic                pend_full;
  logic [4*DIGITS-1:0] pend_hex;
  logic [DIGITS-1:0]   pend_point;
  logic [DIGITS-1:0]   pend_blank;

  assign upd_ready = ~pend_full;

  // Capture and promotion are mutually exclusive: capture needs an
  // empty pending slot, promotion needs a full one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full  <= 1'b0;
      pend_hex   <= '0;
      pend_point <= '0;
      pend_blank <= '0;
      act_hex    <= '0;
      act_point  <= '0;
      act_blank  <= '1;
    end else if (upd_valid && upd_ready) begin
      pend_full  <= 1'b1;
      pend_hex   <= hex_in;
      pend_point <= point_in;
      pend_blank <= blank_in;
    end else if (pend_full && (flush || frame_end)) begin
      pend_full <= 1'b0;
      act_hex   <= pend_hex;
      act_point <= pend_point;
      act_blank <= pend_blank;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed digit scanner feeding a hex 7-segment decoder with dead time.
// Ports: clk, rst_n, en, upd_*, hex/point/blank in; code, point, le, an, frame_done out.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEF,
  parameter int SCAN_CYC = 100000,
  parameter int DEAD_CYC = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   point_in,
  input  logic [DIGITS-1:0]   blank_in,
  output logic [3:0]          code,
  output logic                point,
  output logic                le,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int CW = $clog2(SCAN_CYC);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  phase_t        phase, ph_nxt;
  logic          frame_end;

  logic [4*DIGITS-1:0] act_hex;
  logic [DIGITS-1:0]   act_point;
  logic [DIGITS-1:0]   act_blank;

  assign frame_end = en && (cnt == CNT_LAST) && (idx == IDX_LAST);

  seg_bank_reg #(
    .DIGITS (DIGITS)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (~en),
    .frame_end (frame_end),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .hex_in    (hex_in),
    .point_in  (point_in),
    .blank_in  (blank_in),
    .act_hex   (act_hex),
    .act_point (act_point),
    .act_blank (act_blank)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      phase <= PH_DEAD;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      phase <= ph_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    idx_nxt = idx;
    ph_nxt  = phase;
    if (!en) begin
      cnt_nxt = '0;
      idx_nxt = '0;
      ph_nxt  = PH_DEAD;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      ph_nxt  = PH_DEAD;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt_nxt = cnt + 1'b1;
      unique case (phase)
        PH_DEAD: if (cnt == DEAD_LAST) ph_nxt = PH_ON;
        PH_ON:   ph_nxt = PH_ON;
      endcase
    end
  end

  // Pins are registered from the current slot state, one cycle behind it.
  // code is left alone in DEAD so the decoder inputs do not toggle while dark.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      an         <= AN_OFF[DIGITS-1:0];
      code       <= '0;
      point      <= 1'b0;
      le         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (phase == PH_ON) begin
        an    <= ~(DIGITS'(1) << idx);
        code  <= act_hex[{idx, 2'b00} +: 4];
        point <= act_point[idx];
        le    <= act_blank[idx];
      end else begin
        an    <= AN_OFF[DIGITS-1:0];
        point <= 1'b0;
        le    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with DIGITS=4, SCAN_CYC=8, DEAD_CYC=2.
// Stimulus pushes expected lit slots; a negedge monitor pops and checks them.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] hex_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  code;
  logic        point;
  logic        le;
  logic [3:0]  an;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic       point;
    logic       le;
  } exp_t;

  exp_t sb[$];
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS   (4),
    .SCAN_CYC (8),
    .DEAD_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .hex_in     (hex_in),
    .point_in   (point_in),
    .blank_in   (blank_in),
    .code       (code),
    .point      (point),
    .le         (le),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] c,
                      input logic p, input logic l);
    exp_t e;
    e.an    = a;
    e.code  = c;
    e.point = p;
    e.le    = l;
    sb.push_back(e);
  endtask

  task automatic blank_frame();
    push(4'b1110, 4'h0, 1'b0, 1'b1);
    push(4'b1101, 4'h0, 1'b0, 1'b1);
    push(4'b1011, 4'h0, 1'b0, 1'b1);
    push(4'b0111, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 40);
    check("frame_done_seen", {31'd0, frame_done}, 1);
  endtask

  // Monitor: a lit slot starts when an leaves all-ones.
  initial begin
    exp_t e;
    logic [3:0] prev_an;
    int run_len;
    logic run_ok;
    prev_an = 4'hF;
    run_len = 0;
    run_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (an != 4'hF && prev_an == 4'hF) begin
        run_len = 1;
        run_ok = 1'b0;
        if (mon_en) begin
          if (sb.size() == 0) begin
            check("sb_underflow_an", {28'd0, an}, 32'hF);
          end else begin
            e = sb.pop_front();
            check("slot_an", {28'd0, an}, {28'd0, e.an});
            check("slot_code", {28'd0, code}, {28'd0, e.code});
            check("slot_point", {31'd0, point}, {31'd0, e.point});
            check("slot_le", {31'd0, le}, {31'd0, e.le});
            run_ok = 1'b1;
          end
        end
      end else if (an != 4'hF) begin
        run_len++;
      end else if (prev_an != 4'hF && run_ok) begin
        check("lit_len", run_len, 6);
        run_ok = 1'b0;
      end
      prev_an = an;
    end
  end

  initial begin
    int n;
    // 1. reset
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) begin
      tick();
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_le", {31'd0, le}, 1);
      check("rst_code", {28'd0, code}, 0);
      check("rst_fd", {31'd0, frame_done}, 0);
      check("rst_ready", {31'd0, upd_ready}, 1);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    blank_frame();
    wait_fd(n);
    check("first_fd_cycles", n, 32);

    // 2. update then scan
    blank_frame();
    check("ready_idle", {31'd0, upd_ready}, 1);
    upd_valid = 1'b1;
    hex_in = 16'h1A3F;
    point_in = 4'b0100;
    blank_in = 4'b0000;
    tick();
    upd_valid = 1'b0;
    check("ready_after_cap", {31'd0, upd_ready}, 0);
    push(4'b1110, 4'hF, 1'b0, 1'b0);
    push(4'b1101, 4'h3, 1'b0, 1'b0);
    push(4'b1011, 4'hA, 1'b1, 1'b0);
    push(4'b0111, 4'h1, 1'b0, 1'b0);
    wait_fd(n);
    check("ready_after_boundary", {31'd0, upd_ready}, 1);

    // 3. backpressure
    tick(10);
    upd_valid = 1'b1;
    hex_in = 16'h2222;
    point_in = 4'b0000;
    check("ready_bp_first", {31'd0, upd_ready}, 1);
    tick();
    hex_in = 16'h3333;
    n = 0;
    do begin
      tick();
      n++;
    end while (!upd_ready && n < 40);
    check("stall_cycles", n, 21);
    check("ready_with_fd", {31'd0, frame_done}, 1);
    tick();
    upd_valid = 1'b0;
    check("ready_bp_second", {31'd0, upd_ready}, 0);
    push(4'b1110, 4'h2, 1'b0, 1'b0);
    push(4'b1101, 4'h2, 1'b0, 1'b0);
    push(4'b1011, 4'h2, 1'b0, 1'b0);
    push(4'b0111, 4'h2, 1'b0, 1'b0);
    push(4'b1110, 4'h3, 1'b0, 1'b0);
    push(4'b1101, 4'h3, 1'b0, 1'b0);
    push(4'b1011, 4'h3, 1'b0, 1'b0);
    push(4'b0111, 4'h3, 1'b0, 1'b0);
    wait_fd(n);
    check("ready_free", {31'd0, upd_ready}, 1);

    // 4. blank mask
    upd_valid = 1'b1;
    hex_in = 16'h5678;
    point_in = 4'b0000;
    blank_in = 4'b1010;
    tick();
    upd_valid = 1'b0;
    push(4'b1110, 4'h8, 1'b0, 1'b0);
    push(4'b1101, 4'h7, 1'b0, 1'b1);
    push(4'b1011, 4'h6, 1'b0, 1'b0);
    push(4'b0111, 4'h5, 1'b0, 1'b1);
    wait_fd(n);
    wait_fd(n);

    // 5. enable toggle mid slot 2
    push(4'b1110, 4'h8, 1'b0, 1'b0);
    push(4'b1101, 4'h7, 1'b0, 1'b1);
    tick(18);
    mon_en = 1'b0;
    tick(2);
    en = 1'b0;
    tick();
    check("en_off_an", {28'd0, an}, 32'hF);
    check("en_off_le", {31'd0, le}, 1);
    check("en_off_code", {28'd0, code}, 0);
    check("en_off_point", {31'd0, point}, 0);
    tick(3);
    en = 1'b1;
    mon_en = 1'b1;
    push(4'b1110, 4'h8, 1'b0, 1'b0);
    push(4'b1101, 4'h7, 1'b0, 1'b1);
    push(4'b1011, 4'h6, 1'b0, 1'b0);
    push(4'b0111, 4'h5, 1'b0, 1'b1);
    tick();
    check("resume_dead0", {28'd0, an}, 32'hF);
    tick();
    check("resume_dead1", {28'd0, an}, 32'hF);
    tick();
    check("resume_an", {28'd0, an}, 32'hE);
    check("resume_code", {28'd0, code}, 8);
    wait_fd(n);
    check("resume_fd_cycles", n, 29);

    // 6. reset with an update pending
    upd_valid = 1'b1;
    hex_in = 16'hBEEF;
    point_in = 4'b1111;
    blank_in = 4'b0000;
    check("ready_pre_rst", {31'd0, upd_ready}, 1);
    tick();
    upd_valid = 1'b0;
    mon_en = 1'b0;
    check("pend_before_rst", {31'd0, upd_ready}, 0);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("rst2_ready", {31'd0, upd_ready}, 1);
    check("rst2_an", {28'd0, an}, 32'hF);
    check("rst2_le", {31'd0, le}, 1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    blank_frame();
    blank_frame();
    wait_fd(n);
    wait_fd(n);
    tick(2);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
